apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB3 slave backed by a DEPTH x 32-bit word memory, with programmable wait states,
// address-window decode with pslverr, and a sticky protocol-violation flag.
module apb_slave_mem #(
  parameter int          WAIT_STATES = 1,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        proto_err
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] WIN_BYTES = 33'(4 * DEPTH);
  localparam logic [2:0]  WS        = 3'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state, state_nxt;
  logic [2:0]         wcnt;
  logic [31:0]        addr_lat, wdata_lat;
  logic               write_lat, valid_lat;
  logic [IDX_W-1:0]   idx_lat;
  logic [31:0]        mem [DEPTH];

  logic setup_go, done, proto_set;

  // Offset is taken modulo 2^32, so the window test never overflows near the top of the map.
  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    setup_go  = 1'b0;
    done      = 1'b0;
    proto_set = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          setup_go  = 1'b1;
          state_nxt = ACCESS;
        end else if (psel && penable) begin
          proto_set = 1'b1;
        end
      end
      ACCESS: begin
        if (psel && penable) begin
          // Bus values drifting mid-transfer are flagged; the latched copies stay authoritative.
          if (paddr != addr_lat || pwrite != write_lat || pwdata != wdata_lat)
            proto_set = 1'b1;
          if (wcnt == WS) begin
            pready    = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          proto_set = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pslverr = pready & ~valid_lat;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      wcnt      <= 3'd0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (proto_set)
        proto_err <= 1'b1;
      if (setup_go)
        wcnt <= 3'd0;
      else if (state == ACCESS && psel && penable && !done)
        wcnt <= wcnt + 3'd1;
    end
  end

  // Transfer context captured at the setup edge; meaningful only while in ACCESS.
  always_ff @(posedge hclk) begin
    if (setup_go) begin
      addr_lat  <= paddr;
      wdata_lat <= pwdata;
      write_lat <= pwrite;
      valid_lat <= addr_ok(paddr);
      idx_lat   <= addr_idx(paddr);
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      prdata <= 32'h0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'h0;
    end else begin
      if (setup_go && !pwrite)
        prdata <= addr_ok(paddr) ? mem[addr_idx(paddr)] : 32'h0;
      if (done && write_lat && valid_lat)
        mem[idx_lat] <= wdata_lat;
    end
  end

endmodule
